ps2_keymatrix: RTL and testbench
================================

Name: ps2_keymatrix

Overview:
PS/2 keyboard front end feeding the ULA port-FE read path. It receives PS/2 set-2 frames, decodes make/break/E0 sequences and maintains an 8x5 Spectrum key matrix. The matrix is returned as active-low key_data for the half-rows selected by addr[15:8], together with level-held function-key and modifier flags for the host shell. Runs in the 14 MHz clk_ula domain.

Parameters:
FILTER_LEN, 8, number of consecutive equal samples needed to change the filtered PS2_CLK level
TIMEOUT_CYC, 28000, CLK cycles (2 ms) allowed between falling edges inside a frame before the frame is aborted

Ports:
CLK  input  1  system clock, clk_ula (14 MHz)
RESET  input  1  synchronous reset, active-high
PS2_CLK  input  1  raw PS/2 clock, asynchronous
PS2_DAT  input  1  raw PS/2 data, asynchronous
addr  input  8  CPU address bits A15..A8; a 0 selects a half-row
key_data  output  5  active-low column bits for the selected rows
Fn  output  11  indexed [11:1]; Fn[n]=1 while Fn key n is held
mod  output  3  [2]=either Shift held, [1]=right Ctrl held, [0]=Alt held
frame_err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset is synchronous and active-high: it applies on the CLK edge with RESET=1 and overrides everything else. All keys read as released, so key_data=5'h1F. Fn=0, mod=0, frame_err=0, FSM=IDLE, prefix flags and skip counter are 0. A reset mid-frame discards the partial frame.
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser. The filtered clock goes 0 after FILTER_LEN consecutive synchronised 0s and goes 1 after FILTER_LEN consecutive 1s; otherwise it holds. A sample is taken on the filtered 1->0 transition, using the synchronised PS2_DAT.
- Receiver FSM:
  - IDLE: a sample of 0 moves to DATA with bitcnt=0. A sample of 1 stays in IDLE (no error).
  - DATA: data bits are shifted in LSB first. After 8 bits, move to PARITY.
  - PARITY: the received bit is stored; move to STOP.
  - STOP: return to IDLE. The byte is valid only if stop=1 and the 8 data bits plus the parity bit have odd parity. A valid byte raises an internal byte strobe for one cycle, on the cycle after the stop sample. Otherwise frame_err pulses for 1 cycle.
  - Timeout: the counter clears on every sample and increments while not in IDLE. When it reaches TIMEOUT_CYC the FSM goes to IDLE, the byte is discarded and frame_err pulses.
- Decoder, acting on each byte strobe:
  - F0 sets rel; E0 sets ext.
  - E1 loads skip=7. While skip is nonzero, bytes only decrement skip (Pause is ignored).
  - Any other byte is looked up using {ext, code}. It sets the mapped bit(s) if rel=0 and clears them if rel=1, then clears rel and ext. Unmapped codes (including AA and FA) change nothing except clearing rel and ext.
- Matrix: rows r0..r7 correspond to A8..A15; bit0 is the outermost key of each row.
  - r0: CS Z X C V = 12/59 1A 22 21 2A
  - r1: A S D F G = 1C 1B 23 2B 34
  - r2: Q W E R T = 15 1D 24 2D 2C
  - r3: 1 2 3 4 5 = 16 1E 26 25 2E
  - r4: 0 9 8 7 6 = 45 46 3E 3D 36
  - r5: P O I U Y = 4D 44 43 3C 35
  - r6: Enter L K J H = 5A 4B 42 3B 33
  - r7: Space SS M N B = 29 14(LCtrl) 3A 31 32
- Composite keys each have their own held-bit. The effective matrix is the base matrix OR the composite contributions, so releasing a composite never releases a physically held key.
  - Backspace 66 = CS+0
  - E0 6B = CS+5
  - E0 72 = CS+6
  - E0 75 = CS+7
  - E0 74 = CS+8
- LShift (12) and RShift (59) each have their own held-bit. CS is pressed while either is held.
- key_data is combinational with zero latency: key_data[b] = ~(OR over r with addr[r]=0 of eff[r][b]). If addr=FF, key_data=1F. If several rows are selected, their columns are ORed (wired-AND in active-low terms).
- Fn codes: F1..F11 = 05 06 04 0C 03 0B 83 0A 01 09 78. mod codes: Alt=11, RCtrl=E0 14. E0 11 and E0 12 are ignored.
- Simultaneous events: only one byte strobe can occur per frame, so there is no decoder contention. RESET takes precedence over a strobe on the same cycle.

Test Plan:
- Reset -> key_data=1F for every addr, Fn=0, mod=0, frame_err=0.
- Send valid frame 1C, then addr=FD -> key_data=1E; addr=FE -> 1F. Send F0 1C -> FD reads 1F.
- Send 12 then 66, then F0 66 -> addr=FE reads 1E throughout (CS held); addr=EF reads 1E and then 1F after the release.
- Send a frame with bad parity, then one with stop=0 -> two frame_err pulses; matrix unchanged.
- Send start plus 4 bits, then idle for 28000+ cycles -> frame_err pulse; a following valid 29 gives addr=7F reads 1E.
- Send 05, E0 14, 11 -> Fn[1]=1, mod=3'b011. Send E1 14 77 E1 F0 14 F0 77 -> no matrix change.

Source files
------------

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver and decoder maintaining the Spectrum 8x5 key matrix
// read through port FE, plus level-held function-key and modifier flags.
module ps2_keymatrix #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 28000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  input  logic [7:0]  addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt;
  logic          smp_vld_p0, smp_bit_p0;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          vld_p1;
  logic [7:0]    byte_p1;

  logic          rel, ext;
  logic [2:0]    skip;
  logic [39:0]   base;
  logic          lshift, rshift, alt, rctrl;
  // {Right, Up, Down, Left, Backspace}: each composite key has its own held bit
  logic [4:0]    comp;
  logic [39:0]   eff;
  logic [4:0]    col;

  function automatic logic odd_parity(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction

  // One-hot matrix position (row*5 + bit) of a plain key; zero when unmapped.
  function automatic logic [39:0] matrix_mask(input logic [7:0] code);
    logic       hit;
    logic [5:0] idx;
    hit = 1'b1;
    idx = 6'd0;
    case (code)
      8'h1A: idx = 6'd1;   8'h22: idx = 6'd2;   8'h21: idx = 6'd3;   8'h2A: idx = 6'd4;
      8'h1C: idx = 6'd5;   8'h1B: idx = 6'd6;   8'h23: idx = 6'd7;   8'h2B: idx = 6'd8;
      8'h34: idx = 6'd9;   8'h15: idx = 6'd10;  8'h1D: idx = 6'd11;  8'h24: idx = 6'd12;
      8'h2D: idx = 6'd13;  8'h2C: idx = 6'd14;  8'h16: idx = 6'd15;  8'h1E: idx = 6'd16;
      8'h26: idx = 6'd17;  8'h25: idx = 6'd18;  8'h2E: idx = 6'd19;  8'h45: idx = 6'd20;
      8'h46: idx = 6'd21;  8'h3E: idx = 6'd22;  8'h3D: idx = 6'd23;  8'h36: idx = 6'd24;
      8'h4D: idx = 6'd25;  8'h44: idx = 6'd26;  8'h43: idx = 6'd27;  8'h3C: idx = 6'd28;
      8'h35: idx = 6'd29;  8'h5A: idx = 6'd30;  8'h4B: idx = 6'd31;  8'h42: idx = 6'd32;
      8'h3B: idx = 6'd33;  8'h33: idx = 6'd34;  8'h29: idx = 6'd35;  8'h14: idx = 6'd36;
      8'h3A: idx = 6'd37;  8'h31: idx = 6'd38;  8'h32: idx = 6'd39;
      default: hit = 1'b0;
    endcase
    return hit ? (40'd1 << idx) : 40'd0;
  endfunction

  function automatic logic [11:1] fn_mask(input logic [7:0] code);
    logic [11:1] m;
    m = '0;
    case (code)
      8'h05: m[1]  = 1'b1;
      8'h06: m[2]  = 1'b1;
      8'h04: m[3]  = 1'b1;
      8'h0C: m[4]  = 1'b1;
      8'h03: m[5]  = 1'b1;
      8'h0B: m[6]  = 1'b1;
      8'h83: m[7]  = 1'b1;
      8'h0A: m[8]  = 1'b1;
      8'h01: m[9]  = 1'b1;
      8'h09: m[10] = 1'b1;
      8'h78: m[11] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Stage p0: synchronise, glitch-filter PS2_CLK, sample data on its filtered fall
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign smp_vld_p0 = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
  assign smp_bit_p0 = dat_sync[1];

  // Stage p1: frame assembly, validation and inter-edge timeout
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      bitcnt    <= '0;
      tcnt      <= '0;
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
      if (smp_vld_p0) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!smp_bit_p0) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {smp_bit_p0, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= smp_bit_p0;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (smp_bit_p0 && odd_parity(shreg, par)) begin
              vld_p1  <= 1'b1;
              byte_p1 <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYC)) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // Stage p2: prefix handling and key state update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rel    <= 1'b0;
      ext    <= 1'b0;
      skip   <= '0;
      base   <= '0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      alt    <= 1'b0;
      rctrl  <= 1'b0;
      comp   <= '0;
      Fn     <= '0;
    end else if (vld_p1) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (byte_p1 == 8'hF0) begin
        rel <= 1'b1;
      end else if (byte_p1 == 8'hE0) begin
        ext <= 1'b1;
      end else if (byte_p1 == 8'hE1) begin
        skip <= 3'd7;
      end else begin
        rel <= 1'b0;
        ext <= 1'b0;
        if (!ext) begin
          case (byte_p1)
            8'h12: lshift  <= !rel;
            8'h59: rshift  <= !rel;
            8'h66: comp[0] <= !rel;
            8'h11: alt     <= !rel;
            default: begin
              base <= rel ? (base & ~matrix_mask(byte_p1)) : (base | matrix_mask(byte_p1));
              Fn   <= rel ? (Fn & ~fn_mask(byte_p1)) : (Fn | fn_mask(byte_p1));
            end
          endcase
        end else begin
          case (byte_p1)
            8'h6B: comp[1] <= !rel;
            8'h72: comp[2] <= !rel;
            8'h75: comp[3] <= !rel;
            8'h74: comp[4] <= !rel;
            8'h14: rctrl   <= !rel;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    eff     = base;
    eff[0]  = base[0] | lshift | rshift | (|comp);
    eff[20] = base[20] | comp[0];
    eff[19] = base[19] | comp[1];
    eff[24] = base[24] | comp[2];
    eff[23] = base[23] | comp[3];
    eff[22] = base[22] | comp[4];
    col = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr[r]) col = col | eff[r*5 +: 5];
    end
  end

  assign key_data = ~col;
  assign mod      = {lshift | rshift, rctrl, alt};

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Scoreboard bench for ps2_keymatrix: PS/2 frames in, key-state reference model checked
// against key_data over many addr values, Fn, mod and frame_err pulses.
`timescale 1ns/1ps
module tb_ps2_keymatrix;
  localparam int TIMEOUT_CYC = 28000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic [7:0]  addr;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;
  logic        frame_err;

  always #5 CLK = ~CLK;

  ps2_keymatrix #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .addr(addr), .key_data(key_data), .Fn(Fn), .mod(mod), .frame_err(frame_err)
  );

  typedef struct {
    logic [39:0] mat;
    logic [11:1] fn;
    logic [2:0]  md;
  } snap_t;

  snap_t snap_q[$];
  bit    err_q[$];
  bit    busy;
  int    checks = 0;
  int    failures = 0;

  // Key ids are {E0-prefix, code}; matrix positions are row*5 + bit.
  int rowcodes [40] = '{'h012, 'h01A, 'h022, 'h021, 'h02A,
                        'h01C, 'h01B, 'h023, 'h02B, 'h034,
                        'h015, 'h01D, 'h024, 'h02D, 'h02C,
                        'h016, 'h01E, 'h026, 'h025, 'h02E,
                        'h045, 'h046, 'h03E, 'h03D, 'h036,
                        'h04D, 'h044, 'h043, 'h03C, 'h035,
                        'h05A, 'h04B, 'h042, 'h03B, 'h033,
                        'h029, 'h014, 'h03A, 'h031, 'h032};
  int comp_id  [5]  = '{'h066, 'h16B, 'h172, 'h175, 'h174};
  int comp_pos [5]  = '{20, 19, 24, 23, 22};
  int fn_codes [11] = '{'h05, 'h06, 'h04, 'h0C, 'h03, 'h0B, 'h83, 'h0A, 'h01, 'h09, 'h78};

  bit held[int];
  int m_rel = 0, m_ext = 0, m_skip = 0;
  int pool[$];

  function automatic snap_t expect_now();
    snap_t s;
    s.mat = '0;
    s.fn  = '0;
    s.md  = '0;
    foreach (held[id]) begin
      for (int i = 0; i < 40; i++) if (rowcodes[i] == id) s.mat[i] = 1'b1;
      if (id == 'h012 || id == 'h059) begin
        s.mat[0] = 1'b1;
        s.md[2]  = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
        if (comp_id[i] == id) begin
          s.mat[0] = 1'b1;
          s.mat[comp_pos[i]] = 1'b1;
        end
      end
      for (int i = 0; i < 11; i++) if (fn_codes[i] == id) s.fn[i+1] = 1'b1;
      if (id == 'h011) s.md[0] = 1'b1;
      if (id == 'h114) s.md[1] = 1'b1;
    end
    return s;
  endfunction

  task automatic model_byte(input int b);
    int id;
    if (m_skip > 0) m_skip--;
    else if (b == 'hF0) m_rel = 1;
    else if (b == 'hE0) m_ext = 1;
    else if (b == 'hE1) m_skip = 7;
    else begin
      id = m_ext * 256 + b;
      if (m_rel != 0) held.delete(id);
      else held[id] = 1'b1;
      m_rel = 0;
      m_ext = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    repeat (6) @(posedge CLK);
    PS2_CLK = 1'b0;
    repeat (14) @(posedge CLK);
    PS2_CLK = 1'b1;
    repeat (10) @(posedge CLK);
  endtask

  // kind: 0 = good frame, 1 = bad parity, 2 = stop bit low
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic p;
    p = ~^b;
    if (kind == 1) p = ~p;
    if (kind != 0) err_q.push_back(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(kind == 2 ? 1'b0 : 1'b1);
    PS2_DAT = 1'b1;
    repeat (20) @(posedge CLK);
    if (kind == 0) model_byte(int'(b));
  endtask

  task automatic snapshot();
    int n;
    snap_q.push_back(expect_now());
    n = 0;
    while ((snap_q.size() != 0 || busy) && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain: monitor still busy after %0d cycles, required under 200", n);
    end
  endtask

  task automatic key_event(input int id, input bit release_it);
    if (id >= 256) send_frame(8'hE0, 0);
    if (release_it) send_frame(8'hF0, 0);
    send_frame(8'(id & 'hFF), 0);
  endtask

  task automatic pause_seq();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_frame(seq[i], 0);
  endtask

  // Monitor: every frame_err pulse must be announced; each snapshot is checked over 11 addr values.
  initial begin : monitor
    snap_t      cur;
    int         idx;
    logic [7:0] a;
    logic [4:0] want;
    busy = 1'b0;
    idx  = 0;
    addr = 8'hFF;
    forever begin
      @(negedge CLK);
      if (frame_err === 1'b1) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL frame_err_unexpected: got pulse, required none");
        end else begin
          void'(err_q.pop_front());
        end
      end
      if (!busy && snap_q.size() > 0) begin
        cur  = snap_q.pop_front();
        busy = 1'b1;
        idx  = 0;
        checks++;
        if (err_q.size() != 0) begin
          failures++;
          $display("FAIL frame_err_missing: %0d pulses outstanding, required 0", err_q.size());
          err_q.delete();
        end
      end
      if (busy) begin
        if (idx == 0) a = 8'hFF;
        else if (idx <= 8) a = ~(8'd1 << (idx - 1));
        else a = 8'($urandom);
        addr = a;
        #1;
        want = '0;
        for (int r = 0; r < 8; r++) if (!a[r]) want = want | cur.mat[r*5 +: 5];
        want = ~want;
        checks++;
        if (key_data !== want) begin
          failures++;
          $display("FAIL key_data addr=%02h: got %02h, required %02h", a, key_data, want);
        end
        if (idx == 0) begin
          checks += 3;
          if (Fn !== cur.fn) begin
            failures++;
            $display("FAIL Fn: got %03h, required %03h", Fn, cur.fn);
          end
          if (mod !== cur.md) begin
            failures++;
            $display("FAIL mod: got %03b, required %03b", mod, cur.md);
          end
          if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_idle: got %b, required 0", frame_err);
          end
        end
        idx++;
        if (idx == 11) busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int kind, id;
    RESET   = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (5) @(posedge CLK);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    snapshot();

    send_frame(8'h1C, 0); snapshot();
    send_frame(8'hF0, 0); send_frame(8'h1C, 0); snapshot();

    send_frame(8'h12, 0); snapshot();
    send_frame(8'h66, 0); snapshot();
    send_frame(8'hF0, 0); send_frame(8'h66, 0); snapshot();
    send_frame(8'hF0, 0); send_frame(8'h12, 0); snapshot();

    send_frame(8'h1C, 1);
    send_frame(8'h1C, 2);
    snapshot();

    err_q.push_back(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TIMEOUT_CYC + 200) @(posedge CLK);
    snapshot();
    send_frame(8'h29, 0); snapshot();
    send_frame(8'hF0, 0); send_frame(8'h29, 0);

    send_frame(8'h05, 0);
    send_frame(8'hE0, 0); send_frame(8'h14, 0);
    send_frame(8'h11, 0);
    snapshot();
    pause_seq(); snapshot();

    foreach (rowcodes[i]) pool.push_back(rowcodes[i]);
    foreach (fn_codes[i]) pool.push_back(fn_codes[i]);
    foreach (comp_id[i]) pool.push_back(comp_id[i]);
    pool.push_back('h059); pool.push_back('h011); pool.push_back('h114);
    pool.push_back('h111); pool.push_back('h112); pool.push_back('h0AA);
    pool.push_back('h0FA); pool.push_back('h07E);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 19));
      if (kind < 15) begin
        id = pool[$urandom_range(0, pool.size() - 1)];
        key_event(id, kind >= 9);
      end else if (kind < 19) begin
        send_frame(8'($urandom), (kind < 17) ? 1 : 2);
      end else begin
        pause_seq();
      end
      snapshot();
    end

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    RESET = 1'b0;
    held.delete();
    m_rel = 0; m_ext = 0; m_skip = 0;
    repeat (2) @(posedge CLK);
    snapshot();
    send_frame(8'h1C, 0); snapshot();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
